// File: rtl/fm_s2mm_packer.sv
// Reads a region of the per-column fm buffers in address-major order and packs
// the returned bytes little-endian into AXI-Stream beats for the S2MM DMA.
module fm_s2mm_packer #(
  parameter int CONF_PE_COL         = 16,
  parameter int CONF_FM_BUF_DEPTH   = 1024,
  parameter int CONF_DDR_DATA_WIDTH = 64,
  localparam int AW = $clog2(CONF_FM_BUF_DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           pp_sel,
  input  logic [AW-1:0]                  base_addr,
  input  logic [AW:0]                    len,
  output logic                           busy,
  output logic                           done,
  output logic [CONF_PE_COL-1:0]         fm_rd_en,
  output logic [AW-1:0]                  fm_rd_addr,
  output logic [CONF_PE_COL-1:0]         fm_ping_pong,
  input  logic [CONF_PE_COL*8-1:0]       fm_dout,
  output logic [CONF_DDR_DATA_WIDTH-1:0] s_axis_s2mm_tdata,
  output logic [CONF_DDR_DATA_WIDTH/8-1:0] s_axis_s2mm_tkeep,
  output logic                           s_axis_s2mm_tlast,
  output logic                           s_axis_s2mm_tvalid,
  input  logic                           s_axis_s2mm_tready
);

  localparam int DW   = CONF_DDR_DATA_WIDTH;
  localparam int KW   = DW / 8;
  localparam int CNTW = $clog2(KW) + 1;
  localparam int CW   = (CONF_PE_COL > 1) ? $clog2(CONF_PE_COL) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW:0]     rem_q, rem_d;
  logic [CW-1:0]   col_q, col_d, rd_col_q, rd_col_d;
  logic            pp_q, pp_d, rd_vld_q, rd_vld_d, rd_last_q, rd_last_d;
  logic            done_q, done_d;
  logic [DW-1:0]   asm_data_q, asm_data_d, out_data_q, out_data_d;
  logic [CNTW-1:0] asm_cnt_q, asm_cnt_d;
  logic            asm_full_q, asm_full_d, asm_last_q, asm_last_d;
  logic [KW-1:0]   out_keep_q, out_keep_d;
  logic            out_last_q, out_last_d, out_valid_q, out_valid_d;

  logic                   hs, out_free, move, last_rd, issue;
  logic [DW-1:0]          nd;
  logic [CNTW-1:0]        ncnt;
  logic [7:0]             in_byte;
  logic [CONF_PE_COL-1:0] rd_en;

  function automatic logic [KW-1:0] keep_of(input logic [CNTW-1:0] n);
    logic [KW-1:0] k;
    k = '0;
    for (int unsigned i = 0; i < KW; i++) k[i] = (i < n);
    return k;
  endfunction

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    col_d       = col_q;
    pp_d        = pp_q;
    rd_vld_d    = 1'b0;
    rd_col_d    = rd_col_q;
    rd_last_d   = 1'b0;
    done_d      = 1'b0;
    asm_data_d  = asm_data_q;
    asm_cnt_d   = asm_cnt_q;
    asm_full_d  = asm_full_q;
    asm_last_d  = asm_last_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    nd          = '0;
    ncnt        = '0;
    in_byte     = '0;
    rd_en       = '0;

    hs       = out_valid_q && s_axis_s2mm_tready;
    out_free = !out_valid_q || s_axis_s2mm_tready;
    if (hs) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    // A held complete beat leaves first so the incoming byte finds room.
    move = asm_full_q && out_free;
    if (move) begin
      out_valid_d = 1'b1;
      out_data_d  = asm_data_q;
      out_keep_d  = keep_of(asm_cnt_q);
      out_last_d  = asm_last_q;
      asm_data_d  = '0;
      asm_cnt_d   = '0;
      asm_full_d  = 1'b0;
      asm_last_d  = 1'b0;
    end

    if (rd_vld_q) begin
      in_byte = fm_dout[int'(rd_col_q)*8 +: 8];
      nd      = asm_data_d;
      nd[int'(asm_cnt_d[CNTW-2:0])*8 +: 8] = in_byte;
      ncnt    = asm_cnt_d + CNTW'(1);
      if ((ncnt == CNTW'(KW)) || rd_last_q) begin
        if (out_free && !move) begin
          out_valid_d = 1'b1;
          out_data_d  = nd;
          out_keep_d  = keep_of(ncnt);
          out_last_d  = rd_last_q;
          asm_data_d  = '0;
          asm_cnt_d   = '0;
        end else begin
          asm_data_d  = nd;
          asm_cnt_d   = ncnt;
          asm_full_d  = 1'b1;
          asm_last_d  = rd_last_q;
        end
      end else begin
        asm_data_d = nd;
        asm_cnt_d  = ncnt;
      end
    end

    // Only one read is ever in flight, so stalling on a full assembly
    // register next cycle is enough to never lose a byte.
    last_rd = (col_q == CW'(CONF_PE_COL - 1)) && (rem_q == (AW+1)'(1));
    issue   = (state_q == S_RUN) && !asm_full_d;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            addr_d  = base_addr;
            rem_d   = len;
            col_d   = '0;
            pp_d    = pp_sel;
            state_d = S_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (issue) begin
          rd_en     = CONF_PE_COL'(1) << col_q;
          rd_vld_d  = 1'b1;
          rd_col_d  = col_q;
          rd_last_d = last_rd;
          if (col_q == CW'(CONF_PE_COL - 1)) begin
            col_d  = '0;
            addr_d = addr_q + 1'b1;
            rem_d  = rem_q - 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
          if (last_rd) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (hs && out_last_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      col_q       <= '0;
      pp_q        <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_col_q    <= '0;
      rd_last_q   <= 1'b0;
      done_q      <= 1'b0;
      asm_data_q  <= '0;
      asm_cnt_q   <= '0;
      asm_full_q  <= 1'b0;
      asm_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      col_q       <= col_d;
      pp_q        <= pp_d;
      rd_vld_q    <= rd_vld_d;
      rd_col_q    <= rd_col_d;
      rd_last_q   <= rd_last_d;
      done_q      <= done_d;
      asm_data_q  <= asm_data_d;
      asm_cnt_q   <= asm_cnt_d;
      asm_full_q  <= asm_full_d;
      asm_last_q  <= asm_last_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign busy               = (state_q != S_IDLE);
  assign done               = done_q;
  assign fm_rd_en           = rd_en;
  assign fm_rd_addr         = addr_q;
  assign fm_ping_pong       = {CONF_PE_COL{pp_q}};
  assign s_axis_s2mm_tdata  = out_data_q;
  assign s_axis_s2mm_tkeep  = out_keep_q;
  assign s_axis_s2mm_tlast  = out_last_q;
  assign s_axis_s2mm_tvalid = out_valid_q;

endmodule

// File: tb/tb_fm_s2mm_packer.sv
// Directed bench for fm_s2mm_packer: a 16-column and a 4-column instance fed by
// behavioural fm buffers, checked beat-by-beat against a byte-order model.
module tb_fm_s2mm_packer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start16 = 1'b0, start4 = 1'b0, pp_i = 1'b0, tready = 1'b0;
  logic [9:0]  base_i = '0;
  logic [10:0] len_i = '0;

  logic         busy16, done16, tlast16, tvalid16;
  logic [15:0]  rd_en16, ppo16;
  logic [9:0]   addr16;
  logic [127:0] dout16 = '0;
  logic [63:0]  tdata16;
  logic [7:0]   tkeep16;

  logic         busy4, done4, tlast4, tvalid4;
  logic [3:0]   rd_en4, ppo4;
  logic [9:0]   addr4;
  logic [31:0]  dout4 = '0;
  logic [63:0]  tdata4;
  logic [7:0]   tkeep4;

  fm_s2mm_packer #(.CONF_PE_COL(16), .CONF_FM_BUF_DEPTH(1024), .CONF_DDR_DATA_WIDTH(64)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .pp_sel(pp_i), .base_addr(base_i), .len(len_i),
    .busy(busy16), .done(done16), .fm_rd_en(rd_en16), .fm_rd_addr(addr16), .fm_ping_pong(ppo16),
    .fm_dout(dout16), .s_axis_s2mm_tdata(tdata16), .s_axis_s2mm_tkeep(tkeep16),
    .s_axis_s2mm_tlast(tlast16), .s_axis_s2mm_tvalid(tvalid16), .s_axis_s2mm_tready(tready));

  fm_s2mm_packer #(.CONF_PE_COL(4), .CONF_FM_BUF_DEPTH(1024), .CONF_DDR_DATA_WIDTH(64)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .pp_sel(pp_i), .base_addr(base_i), .len(len_i),
    .busy(busy4), .done(done4), .fm_rd_en(rd_en4), .fm_rd_addr(addr4), .fm_ping_pong(ppo4),
    .fm_dout(dout4), .s_axis_s2mm_tdata(tdata4), .s_axis_s2mm_tkeep(tkeep4),
    .s_axis_s2mm_tlast(tlast4), .s_axis_s2mm_tvalid(tvalid4), .s_axis_s2mm_tready(tready));

  // Buffer contents: byte = (addr*PE_COL + col) mod 256, inverted-ish by 0xA5 on pong.
  function automatic logic [7:0] fbyte(input bit pp, input int c, input int a, input int pe);
    int v;
    v = a * pe + c;
    return 8'(v) ^ (pp ? 8'hA5 : 8'h00);
  endfunction

  always @(posedge clk) begin
    for (int c = 0; c < 16; c++)
      if (rd_en16[c]) dout16[c*8 +: 8] <= fbyte(ppo16[c], c, int'(addr16), 16);
    for (int c = 0; c < 4; c++)
      if (rd_en4[c]) dout4[c*8 +: 8] <= fbyte(ppo4[c], c, int'(addr4), 4);
  end

  int sel = 0;
  logic        busy_v, done_v, tv_v, tl_v;
  logic [15:0] rd_en_v;
  logic [9:0]  addr_v;
  logic [63:0] td_v;
  logic [7:0]  tk_v;
  always_comb begin
    busy_v  = sel ? busy4 : busy16;
    done_v  = sel ? done4 : done16;
    tv_v    = sel ? tvalid4 : tvalid16;
    tl_v    = sel ? tlast4 : tlast16;
    td_v    = sel ? tdata4 : tdata16;
    tk_v    = sel ? tkeep4 : tkeep16;
    rd_en_v = sel ? {12'b0, rd_en4} : rd_en16;
    addr_v  = sel ? addr4 : addr16;
  end

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    int sel; int base; int len; bit pp; bit rmode; bit extra;
    int beats; logic [7:0] klast; logic [63:0] d0; logic [63:0] dl; int tv;
  } vec_t;

  task automatic run_xfer(input int idx, input vec_t v);
    int pe, nbytes, nb, got, reads, bad_rd, stall_bad, first_tv, hs_cyc, done_cyc, n;
    logic busy_at_done;
    logic [7:0]  eb[$];
    logic [63:0] ed, first_d, last_d, pd;
    logic [7:0]  ek, last_k, pk;
    logic        el, pl, pstall;
    logic [15:0] exp_en;
    logic [9:0]  exp_addr;
    pe = v.sel ? 4 : 16;
    for (int a = 0; a < v.len; a++)
      for (int c = 0; c < pe; c++) eb.push_back(fbyte(v.pp, c, (v.base + a) % 1024, pe));
    nbytes = eb.size();
    nb = (nbytes + 7) / 8;
    got = 0; reads = 0; bad_rd = 0; stall_bad = 0;
    first_tv = -1; hs_cyc = -1; done_cyc = -1; n = 0;
    busy_at_done = 1'b1; first_d = '1; last_d = '1; last_k = '1;
    pd = '0; pk = '0; pl = 1'b0; pstall = 1'b0;
    sel = v.sel;
    @(negedge clk);
    base_i = 10'(v.base); len_i = 11'(v.len); pp_i = v.pp; tready = 1'b1;
    if (v.sel != 0) start4 = 1'b1; else start16 = 1'b1;
    while (done_cyc < 0 && n < 4000) begin
      @(negedge clk);
      n++;
      start16 = 1'b0; start4 = 1'b0;
      if (v.extra && n == 5) begin
        base_i = 10'd300; len_i = 11'd3;
        if (v.sel != 0) start4 = 1'b1; else start16 = 1'b1;
      end
      tready = v.rmode ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (rd_en_v != '0) begin
        exp_en   = 16'(1) << (reads % pe);
        exp_addr = 10'((v.base + reads / pe) % 1024);
        if (rd_en_v !== exp_en || addr_v !== exp_addr) bad_rd++;
        reads++;
      end
      if (pstall && (!tv_v || td_v !== pd || tk_v !== pk || tl_v !== pl)) stall_bad++;
      if (tv_v && first_tv < 0) first_tv = n;
      if (tv_v && tready) begin
        ed = '0; ek = '0;
        for (int i = 0; i < 8; i++)
          if (got * 8 + i < nbytes) begin
            ed[i*8 +: 8] = eb[got*8 + i];
            ek[i] = 1'b1;
          end
        el = (got == nb - 1);
        chk($sformatf("v%0d_beat%0d_data", idx, got), td_v, ed);
        chk($sformatf("v%0d_beat%0d_keep", idx, got), 64'(tk_v), 64'(ek));
        chk($sformatf("v%0d_beat%0d_last", idx, got), 64'(tl_v), 64'(el));
        if (got == 0) first_d = td_v;
        last_d = td_v; last_k = tk_v;
        got++;
        hs_cyc = n;
      end
      if (done_v) begin
        done_cyc = n;
        busy_at_done = busy_v;
      end
      pstall = tv_v && !tready;
      pd = td_v; pk = tk_v; pl = tl_v;
    end
    tready = 1'b1;
    chk($sformatf("v%0d_done_seen", idx), 64'(done_cyc >= 0), 64'(1));
    chk($sformatf("v%0d_beats", idx), 64'(got), 64'(v.beats));
    chk($sformatf("v%0d_first_data", idx), first_d, v.d0);
    chk($sformatf("v%0d_last_data", idx), last_d, v.dl);
    chk($sformatf("v%0d_last_keep", idx), 64'(last_k), 64'(v.klast));
    chk($sformatf("v%0d_first_tvalid_cycle", idx), 64'(first_tv), 64'(v.tv));
    chk($sformatf("v%0d_done_after_last_hs", idx), 64'(done_cyc), 64'(hs_cyc + 1));
    chk($sformatf("v%0d_busy_at_done", idx), 64'(busy_at_done), 64'(0));
    chk($sformatf("v%0d_rd_seq_errors", idx), 64'(bad_rd), 64'(0));
    chk($sformatf("v%0d_reads", idx), 64'(reads), 64'(v.len * pe));
    chk($sformatf("v%0d_stall_unstable", idx), 64'(stall_bad), 64'(0));
  endtask

  vec_t vecs[7];
  vec_t vrst;

  initial begin
    int n, got, bad;
    vecs[0] = '{0, 0,    1,  1'b0, 1'b0, 1'b0, 2,   8'hFF, 64'h0706050403020100, 64'h0F0E0D0C0B0A0908, 10};
    vecs[1] = '{1, 0,    3,  1'b0, 1'b0, 1'b0, 2,   8'h0F, 64'h0706050403020100, 64'h000000000B0A0908, 10};
    vecs[2] = '{0, 1022, 4,  1'b0, 1'b0, 1'b0, 8,   8'hFF, 64'hE7E6E5E4E3E2E1E0, 64'h1F1E1D1C1B1A1918, 10};
    vecs[3] = '{0, 5,    64, 1'b1, 1'b1, 1'b0, 128, 8'hFF, 64'hF2F3F0F1F6F7F4F5, 64'hEAEBE8E9EEEFECED, 10};
    vecs[4] = '{1, 1020, 5,  1'b0, 1'b1, 1'b0, 3,   8'h0F, 64'hF7F6F5F4F3F2F1F0, 64'h0000000003020100, 10};
    vecs[5] = '{1, 0,    1,  1'b0, 1'b0, 1'b0, 1,   8'h0F, 64'h0000000003020100, 64'h0000000003020100, 6};
    vecs[6] = '{0, 0,    1,  1'b0, 1'b0, 1'b1, 2,   8'hFF, 64'h0706050403020100, 64'h0F0E0D0C0B0A0908, 10};
    vrst    = '{0, 0,    8,  1'b1, 1'b0, 1'b0, 16,  8'hFF, 64'hA2A3A0A1A6A7A4A5, 64'hDADBD8D9DEDFDCDD, 10};

    repeat (3) @(negedge clk);
    #1;
    chk("reset_ctrl16", 64'({busy16, done16, tvalid16, tlast16, tkeep16, rd_en16, addr16, ppo16}), 64'(0));
    chk("reset_tdata16", tdata16, 64'(0));
    chk("reset_ctrl4", 64'({busy4, done4, tvalid4, tlast4, tkeep4, rd_en4, addr4, ppo4}), 64'(0));
    chk("reset_tdata4", tdata4, 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_xfer(i, vecs[i]);

    // len = 0: done one cycle after start, no beats.
    sel = 0;
    @(negedge clk);
    len_i = '0; base_i = 10'd7; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    #1;
    chk("len0_done_t1", 64'(done16), 64'(1));
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      #1;
      if (tvalid16 || busy16 || done16 || rd_en16 != '0) bad++;
    end
    chk("len0_quiet", 64'(bad), 64'(0));

    // Reset during beat 3 of a 16-beat transfer.
    @(negedge clk);
    base_i = '0; len_i = 11'd8; pp_i = 1'b1; tready = 1'b1; start16 = 1'b1;
    n = 0; got = 0;
    while (n < 200) begin
      @(negedge clk);
      start16 = 1'b0;
      #1;
      n++;
      if (got == 2 && tvalid16) break;
      if (tvalid16) got++;
    end
    chk("rst_reach_beat3", 64'(n < 200), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ctrl", 64'({busy16, done16, tvalid16, tlast16, tkeep16, rd_en16, addr16, ppo16}), 64'(0));
    chk("rst_mid_tdata", tdata16, 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      #1;
      if (done16 || busy16 || tvalid16) bad++;
    end
    chk("rst_no_done", 64'(bad), 64'(0));
    run_xfer(7, vrst);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
